// File: rtl/phy_rx_flit_framer.sv
// PHY receive framer: groups word-aligned 8b/10b symbols into comma, ACK and data flits.
// Optional mid-word idle timeout is enabled with `define RX_FRAMER_TIMEOUT_EN.
package phy_types_pkg;
  localparam logic [9:0] START_COMMA    = 10'h0FA;
  localparam logic [9:0] END_COMMA      = 10'h0F9;
  localparam logic [9:0] GRTCRED0_COMMA = 10'h0F3;
  localparam logic [9:0] GRTCRED1_COMMA = 10'h0F5;
  localparam logic [9:0] ACK_COMMA      = 10'h0F8;

  localparam logic [1:0] SELECT_COMMA_1_FLIT = 2'd0;
  localparam logic [1:0] SELECT_COMMA_2_FLIT = 2'd1;
  localparam logic [1:0] SELECT_COMMA_DATA   = 2'd2;
endpackage

module phy_rx_flit_framer
  import phy_types_pkg::*;
#(
  parameter int PORTCOUNT      = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    sym_valid,
  input  logic [9:0]              sym,
  output logic [10*PORTCOUNT-1:0] enc_flit,
  output logic [1:0]              comma_length_sel,
  output logic                    done,
  output logic                    err
);

  localparam int CW = $clog2(PORTCOUNT+1);

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_DATA} state_t;

  state_t                    state;
  logic [CW-1:0]             cnt;
  logic [PORTCOUNT-1:0][9:0] asm_buf;
  logic [PORTCOUNT-1:0][9:0] full_word;
  logic [10*PORTCOUNT-1:0]   ack_word;
  logic [10*PORTCOUNT-1:0]   c1_word;
  logic                      is_c1, is_ack, is_comma;

  // A non-positive timeout is meaningless; the block still elaborates but never times out.
  if (TIMEOUT_CYCLES < 1) begin : g_tmo_degenerate
  end

  always_comb begin
    is_c1    = (sym == START_COMMA) || (sym == END_COMMA) ||
               (sym == GRTCRED0_COMMA) || (sym == GRTCRED1_COMMA);
    is_ack   = (sym == ACK_COMMA);
    is_comma = is_c1 || is_ack;
  end

  // The last data symbol goes straight to the output, bypassing the buffer.
  always_comb begin
    full_word                = asm_buf;
    full_word[PORTCOUNT-1]   = sym;
    ack_word                 = '0;
    ack_word[19:0]           = {ACK_COMMA, sym};
    c1_word                  = '0;
    c1_word[9:0]             = sym;
  end

`ifdef RX_FRAMER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] tmo;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state            <= S_IDLE;
      cnt              <= '0;
      asm_buf          <= '0;
      enc_flit         <= '0;
      comma_length_sel <= SELECT_COMMA_1_FLIT;
      done             <= 1'b0;
      err              <= 1'b0;
`ifdef RX_FRAMER_TIMEOUT_EN
      tmo              <= '0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (sym_valid) begin
`ifdef RX_FRAMER_TIMEOUT_EN
        tmo <= '0;
`endif
        if (state == S_ACK && !is_comma) begin
          enc_flit         <= ack_word;
          comma_length_sel <= SELECT_COMMA_2_FLIT;
          done             <= 1'b1;
          state            <= S_IDLE;
        end else if (state == S_DATA && !is_comma) begin
          asm_buf[cnt] <= sym;
          if (cnt == CW'(PORTCOUNT-1)) begin
            enc_flit         <= full_word;
            comma_length_sel <= SELECT_COMMA_DATA;
            done             <= 1'b1;
            cnt              <= '0;
            state            <= S_IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end else begin
          // IDLE handling; a comma arriving mid-word aborts and is then framed normally.
          err   <= (state != S_IDLE);
          cnt   <= '0;
          state <= S_IDLE;
          if (is_c1) begin
            enc_flit         <= c1_word;
            comma_length_sel <= SELECT_COMMA_1_FLIT;
            done             <= 1'b1;
          end else if (is_ack) begin
            state <= S_ACK;
          end else begin
            asm_buf[0] <= sym;
            cnt        <= CW'(1);
            state      <= S_DATA;
          end
        end
      end
`ifdef RX_FRAMER_TIMEOUT_EN
      else if (state != S_IDLE) begin
        if (tmo == TW'(TIMEOUT_CYCLES-1)) begin
          err   <= 1'b1;
          tmo   <= '0;
          cnt   <= '0;
          state <= S_IDLE;
        end else begin
          tmo <= tmo + TW'(1);
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_phy_rx_flit_framer.sv
// Directed bench for phy_rx_flit_framer (PORTCOUNT=5, TIMEOUT_CYCLES=64).
module tb_phy_rx_flit_framer;
  import phy_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST;
  logic        sym_valid;
  logic [9:0]  sym;
  logic [49:0] enc_flit;
  logic [1:0]  comma_length_sel;
  logic        done, err;

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] D = 10'h274;

  phy_rx_flit_framer #(.PORTCOUNT(5), .TIMEOUT_CYCLES(64)) dut (
    .CLK(CLK), .RST(RST), .sym_valid(sym_valid), .sym(sym),
    .enc_flit(enc_flit), .comma_length_sel(comma_length_sel),
    .done(done), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs applied at a negedge; returns at the next negedge with the result visible.
  task automatic cyc(input logic v, input logic [9:0] s);
    sym_valid = v;
    sym       = s;
    @(negedge CLK);
  endtask

  task automatic chk_word(input string tag, input logic [1:0] sel, input logic [49:0] flit, input logic e);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_sel"},  64'(comma_length_sel), 64'(sel));
    check({tag, "_flit"}, 64'(enc_flit), 64'(flit));
    check({tag, "_err"},  64'(err), 64'(e));
  endtask

  initial begin
    int nerr, ndone;
    RST = 1'b1; sym_valid = 1'b0; sym = '0;
    @(negedge CLK); @(negedge CLK);
    check("rst_flit", 64'(enc_flit), 64'd0);
    check("rst_sel",  64'(comma_length_sel), 64'(SELECT_COMMA_1_FLIT));
    check("rst_done", 64'(done), 64'd0);
    check("rst_err",  64'(err), 64'd0);
    RST = 1'b0;

    // START, five data, END back to back
    cyc(1, START_COMMA);
    chk_word("start", SELECT_COMMA_1_FLIT, {40'd0, START_COMMA}, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, D);
      check("data_nodone", 64'(done), 64'd0);
    end
    cyc(1, D);
    chk_word("data5", SELECT_COMMA_DATA, {5{D}}, 1'b0);
    cyc(1, END_COMMA);
    chk_word("end", SELECT_COMMA_1_FLIT, {40'd0, END_COMMA}, 1'b0);
    cyc(0, 10'h000);
    check("hold_done", 64'(done), 64'd0);
    check("hold_flit", 64'(enc_flit), 64'({40'd0, END_COMMA}));

    // ACK pair
    cyc(1, ACK_COMMA);
    check("ack_nodone", 64'(done), 64'd0);
    cyc(1, D);
    chk_word("ack", SELECT_COMMA_2_FLIT, {30'd0, ACK_COMMA, D}, 1'b0);

    // Aborted flit followed by a clean one
    for (int i = 0; i < 3; i++) cyc(1, D);
    check("abort_pre_err", 64'(err), 64'd0);
    cyc(1, GRTCRED0_COMMA);
    chk_word("abort", SELECT_COMMA_1_FLIT, {40'd0, GRTCRED0_COMMA}, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      cyc(1, 10'(i));
      check("post_abort_err", 64'(err), 64'd0);
    end
    chk_word("post_abort", SELECT_COMMA_DATA, {10'h005, 10'h004, 10'h003, 10'h002, 10'h001}, 1'b0);

    // ACK aborted by a comma
    cyc(1, ACK_COMMA);
    cyc(1, START_COMMA);
    chk_word("ack_abort", SELECT_COMMA_1_FLIT, {40'd0, START_COMMA}, 1'b1);

    // Gap of three idle cycles mid-flit
    cyc(1, 10'h011); cyc(1, 10'h022);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 10'h3FF);
      check("gap_err", 64'(err), 64'd0);
      check("gap_done", 64'(done), 64'd0);
    end
    cyc(1, 10'h033); cyc(1, 10'h044); cyc(1, 10'h055);
    chk_word("gap", SELECT_COMMA_DATA, {10'h055, 10'h044, 10'h033, 10'h022, 10'h011}, 1'b0);

    // Reset mid-word
    cyc(1, D); cyc(1, D);
    sym_valid = 1'b0;
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    check("mid_rst_err",  64'(err), 64'd0);
    check("mid_rst_flit", 64'(enc_flit), 64'd0);
    cyc(1, START_COMMA);
    chk_word("after_rst", SELECT_COMMA_1_FLIT, {40'd0, START_COMMA}, 1'b0);

    // Long idle after two data symbols
    cyc(1, 10'h101); cyc(1, 10'h102);
    nerr = 0; ndone = 0;
    for (int i = 0; i < 66; i++) begin
      cyc(0, 10'h000);
      nerr  += int'(err);
      ndone += int'(done);
    end
    check("idle_done_cnt", 64'(ndone), 64'd0);
`ifdef RX_FRAMER_TIMEOUT_EN
    check("tmo_err_cnt", 64'(nerr), 64'd1);
    for (int i = 1; i <= 5; i++) cyc(1, 10'(10'h200 + i));
    chk_word("after_tmo", SELECT_COMMA_DATA, {10'h205, 10'h204, 10'h203, 10'h202, 10'h201}, 1'b0);
`else
    check("no_tmo_err_cnt", 64'(nerr), 64'd0);
    cyc(1, 10'h103); cyc(1, 10'h104);
    check("no_tmo_wait", 64'(done), 64'd0);
    cyc(1, 10'h105);
    chk_word("no_tmo", SELECT_COMMA_DATA, {10'h105, 10'h104, 10'h103, 10'h102, 10'h101}, 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
